// File: rtl/exec_ctrl.sv
// Execute-stage sequencer: decodes a latched instruction and drives ALU,
// register-file, memory-path and PC controls as a Moore FSM.
module exec_ctrl #(
    parameter int MFC_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_done,
    input  logic [15:0] ir,
    input  logic        MFC,
    output logic [3:0]  src_a_sel,
    output logic [3:0]  src_b_sel,
    output logic [3:0]  dst_sel,
    output logic        rf_we,
    output logic [2:0]  alu_op,
    output logic        alu_out_en,
    output logic        MAR_EN,
    output logic        mem_EN,
    output logic        mem_RW,
    output logic        MDR_EN_read,
    output logic        MDR_EN_write,
    output logic        MDR_out,
    output logic        PC_inc,
    output logic        PC_load,
    output logic        done,
    output logic        halted,
    output logic        illegal,
    output logic        bus_err
);

    localparam int CW = (MFC_TIMEOUT > 1) ? $clog2(MFC_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MFC_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_DECODE = 4'd1,
        S_ALU    = 4'd2,
        S_WB     = 4'd3,
        S_ADDR   = 4'd4,
        S_MEMRD  = 4'd5,
        S_LDWB   = 4'd6,
        S_MEMWR  = 4'd7,
        S_JMP    = 4'd8,
        S_RETIRE = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     ir_q, ir_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            bus_err_q, bus_err_d;
    logic [3:0]      op_s;

    assign op_s    = ir_q[15:12];
    assign bus_err = bus_err_q;

    // State, instruction and wait-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ir_q       <= 16'h0000;
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Next-state logic; MFC only matters in the two memory wait states
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        wait_cnt_d = wait_cnt_q;
        bus_err_d  = bus_err_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_done) begin
                    ir_d    = ir;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DECODE: begin
                wait_cnt_d = '0;
                case (op_s)
                    4'd0:                      state_d = S_RETIRE;
                    4'd1, 4'd2, 4'd3, 4'd4:    state_d = S_ALU;
                    4'd5, 4'd6:                state_d = S_ADDR;
                    4'd7:                      state_d = S_JMP;
                    4'd8:                      state_d = S_HALT;
                    default:                   state_d = S_RETIRE;
                endcase
            end
            S_ALU:  state_d = S_WB;
            S_WB:   state_d = S_RETIRE;
            S_ADDR: begin
                wait_cnt_d = '0;
                if (op_s == 4'd6) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMRD, S_MEMWR: begin
                // MFC on the final allowed cycle still counts as success
                if (MFC) begin
                    state_d = (state_q == S_MEMRD) ? S_LDWB : S_RETIRE;
                end else if (wait_cnt_q == CNT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = S_RETIRE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_ONE;
                end
            end
            S_LDWB:   state_d = S_RETIRE;
            S_JMP:    state_d = S_RETIRE;
            S_RETIRE: state_d = S_IDLE;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore output decode from state and latched instruction
    always_comb begin
        src_a_sel    = 4'd0;
        src_b_sel    = 4'd0;
        dst_sel      = 4'd0;
        rf_we        = 1'b0;
        alu_op       = 3'b000;
        alu_out_en   = 1'b0;
        MAR_EN       = 1'b0;
        mem_EN       = 1'b0;
        mem_RW       = 1'b0;
        MDR_EN_read  = 1'b0;
        MDR_EN_write = 1'b0;
        MDR_out      = 1'b0;
        PC_inc       = 1'b0;
        PC_load      = 1'b0;
        done         = 1'b0;
        halted       = 1'b0;
        illegal      = 1'b0;
        if (state_q != S_IDLE) begin
            src_a_sel = ir_q[7:4];
            src_b_sel = ir_q[3:0];
            dst_sel   = ir_q[11:8];
        end else begin
            src_a_sel = 4'd0;
        end
        case (state_q)
            S_ALU: alu_op = op_s[2:0];
            S_WB: begin
                alu_op     = op_s[2:0];
                alu_out_en = 1'b1;
                rf_we      = 1'b1;
            end
            S_ADDR: begin
                alu_op     = 3'b000;
                alu_out_en = 1'b1;
                MAR_EN     = 1'b1;
            end
            S_MEMRD: begin
                mem_EN      = 1'b1;
                mem_RW      = 1'b1;
                MDR_EN_read = 1'b1;
            end
            S_LDWB: begin
                MDR_out = 1'b1;
                rf_we   = 1'b1;
            end
            S_MEMWR: begin
                mem_EN       = 1'b1;
                mem_RW       = 1'b0;
                MDR_EN_write = 1'b1;
            end
            S_JMP: PC_load = 1'b1;
            S_RETIRE: begin
                done    = 1'b1;
                PC_inc  = (op_s != 4'd7);
                illegal = (op_s >= 4'd9);
            end
            S_HALT:  halted = 1'b1;
            default: done = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle output trace, checked every cycle.
module tb_exec_ctrl;

    localparam int TO = 16;

    typedef struct packed {
        logic [3:0] sa;
        logic [3:0] sb;
        logic [3:0] ds;
        logic       rf_we;
        logic [2:0] alu_op;
        logic       alu_out_en;
        logic       mar_en;
        logic       mem_en;
        logic       mem_rw;
        logic       mdr_rd;
        logic       mdr_wr;
        logic       mdr_out;
        logic       pc_inc;
        logic       pc_load;
        logic       done;
        logic       halted;
        logic       illegal;
        logic       bus_err;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_done = 1'b0;
    logic [15:0] ir_in = 16'h0000;
    logic        MFC = 1'b0;
    logic [3:0]  src_a_sel, src_b_sel, dst_sel;
    logic        rf_we, alu_out_en, MAR_EN, mem_EN, mem_RW;
    logic [2:0]  alu_op;
    logic        MDR_EN_read, MDR_EN_write, MDR_out, PC_inc, PC_load;
    logic        done, halted, illegal, bus_err;
    outs_t       act;

    int total = 0;
    int bad   = 0;
    bit model_be = 1'b0;
    outs_t exp_q[$];
    outs_t exp_seq[$];
    bit    mfc_seq[$];
    bit    fd_seq[$];

    exec_ctrl #(.MFC_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .fetch_done(fetch_done), .ir(ir_in), .MFC(MFC),
        .src_a_sel(src_a_sel), .src_b_sel(src_b_sel), .dst_sel(dst_sel),
        .rf_we(rf_we), .alu_op(alu_op), .alu_out_en(alu_out_en),
        .MAR_EN(MAR_EN), .mem_EN(mem_EN), .mem_RW(mem_RW),
        .MDR_EN_read(MDR_EN_read), .MDR_EN_write(MDR_EN_write), .MDR_out(MDR_out),
        .PC_inc(PC_inc), .PC_load(PC_load), .done(done),
        .halted(halted), .illegal(illegal), .bus_err(bus_err)
    );

    assign act = '{sa: src_a_sel, sb: src_b_sel, ds: dst_sel, rf_we: rf_we,
                   alu_op: alu_op, alu_out_en: alu_out_en, mar_en: MAR_EN,
                   mem_en: mem_EN, mem_rw: mem_RW, mdr_rd: MDR_EN_read,
                   mdr_wr: MDR_EN_write, mdr_out: MDR_out, pc_inc: PC_inc,
                   pc_load: PC_load, done: done, halted: halted,
                   illegal: illegal, bus_err: bus_err};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got=timeout required=finish");
        $fatal(1);
    end

    // Single compare point: one expected trace entry per cycle, mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            outs_t e;
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL trace t=%0t got=%h required=%h", $time, act, e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    function automatic void push(input outs_t o, input bit m, input bit f);
        exp_seq.push_back(o);
        mfc_seq.push_back(m);
        fd_seq.push_back(f);
    endfunction

    // Instruction-level model: expected outputs per cycle after the latch edge.
    // mfc_at = wait cycle (1-based) on which MFC arrives, 0 = never.
    task automatic build(input logic [15:0] instr, input int mfc_at, input bit noise);
        outs_t b, o;
        int op;
        int nw;
        exp_seq.delete(); mfc_seq.delete(); fd_seq.delete();
        op = int'(instr[15:12]);
        b = '0;
        b.sa = instr[7:4]; b.sb = instr[3:0]; b.ds = instr[11:8];
        b.bus_err = model_be;
        push(b, noise, noise);
        if (op >= 1 && op <= 4) begin
            o = b; o.alu_op = instr[14:12]; push(o, noise, noise);
            o.alu_out_en = 1'b1; o.rf_we = 1'b1; push(o, noise, noise);
        end else if (op == 5 || op == 6) begin
            o = b; o.alu_out_en = 1'b1; o.mar_en = 1'b1; push(o, noise, noise);
            nw = (mfc_at == 0) ? TO : mfc_at;
            for (int w = 1; w <= nw; w++) begin
                o = b; o.mem_en = 1'b1;
                if (op == 5) begin o.mem_rw = 1'b1; o.mdr_rd = 1'b1; end
                else o.mdr_wr = 1'b1;
                push(o, (w == mfc_at), noise);
            end
            if (mfc_at == 0) begin
                model_be = 1'b1;
                b.bus_err = 1'b1;
            end else if (op == 5) begin
                o = b; o.mdr_out = 1'b1; o.rf_we = 1'b1; push(o, noise, noise);
            end
        end else if (op == 7) begin
            o = b; o.pc_load = 1'b1; push(o, noise, noise);
        end
        if (op == 8) begin
            for (int k = 0; k < 6; k++) begin
                o = b; o.halted = 1'b1; push(o, noise, (k % 2) == 0);
            end
        end else begin
            o = b; o.done = 1'b1; o.pc_inc = (op != 7); o.illegal = (op >= 9);
            push(o, noise, noise);
            o = '0; o.bus_err = model_be;
            push(o, 1'b0, 1'b0);
        end
    endtask

    task automatic run(input logic [15:0] instr, input int mfc_at, input bit noise, input int ncut);
        int n;
        build(instr, mfc_at, noise);
        while (ncut > 0 && exp_seq.size() > ncut) begin
            void'(exp_seq.pop_back()); void'(mfc_seq.pop_back()); void'(fd_seq.pop_back());
        end
        ir_in = instr;
        fetch_done = 1'b1;
        @(posedge clk); #1;
        fetch_done = 1'b0;
        if (noise) ir_in = 16'h1FFF;
        n = exp_seq.size();
        for (int k = 0; k < n; k++) exp_q.push_back(exp_seq[k]);
        for (int k = 0; k < n; k++) begin
            MFC = mfc_seq[k];
            fetch_done = fd_seq[k];
            @(posedge clk); #1;
        end
        MFC = 1'b0;
        fetch_done = 1'b0;
    endtask

    initial begin
        outs_t lit;
        bit save_be;
        int cnt;

        #3;
        chk("reset_outputs", 32'(act), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Pin the model itself against hand-derived values
        build(16'h1123, 1, 1'b0);
        chk("model_add_len", 32'(exp_seq.size()), 32'd5);
        lit = '0; lit.sa = 4'd2; lit.sb = 4'd3; lit.ds = 4'd1;
        lit.rf_we = 1'b1; lit.alu_op = 3'b001; lit.alu_out_en = 1'b1;
        chk("model_add_wb", 32'(exp_seq[2]), 32'(lit));
        lit = '0; lit.sa = 4'd2; lit.sb = 4'd3; lit.ds = 4'd1;
        lit.done = 1'b1; lit.pc_inc = 1'b1;
        chk("model_add_retire", 32'(exp_seq[3]), 32'(lit));
        save_be = model_be;
        build(16'h6030, 0, 1'b0);
        cnt = 0;
        foreach (exp_seq[i]) if (exp_seq[i].mdr_wr) cnt++;
        chk("model_st_wait_cycles", 32'(cnt), 32'd16);
        model_be = save_be;

        run(16'h1123, 0, 1'b1, 0);   // ADD with fetch_done/MFC noise
        run(16'h2456, 0, 1'b0, 0);   // SUB
        run(16'h3789, 0, 1'b0, 0);   // AND
        run(16'h4ABC, 0, 1'b0, 0);   // OR
        run(16'h5240, 3, 1'b1, 0);   // LD, MFC on third wait cycle
        run(16'h5240, 1, 1'b0, 0);   // LD, MFC on first wait cycle
        run(16'h6030, TO, 1'b0, 0);  // ST, MFC on last allowed cycle
        chk("bus_err_clear_after_late_mfc", 32'(bus_err), 32'd0);
        run(16'h7050, 0, 1'b0, 0);   // JMP
        run(16'hA123, 0, 1'b0, 0);   // illegal
        run(16'h6030, 0, 1'b0, 0);   // ST timeout
        chk("bus_err_after_timeout", 32'(bus_err), 32'd1);
        run(16'h0ABC, 0, 1'b0, 0);   // NOP, bus_err stays sticky

        // Reset in the middle of an LD memory wait
        run(16'h5240, 0, 1'b0, 4);
        rst = 1'b1;
        model_be = 1'b0;
        #1;
        chk("reset_mid_memrd", 32'(act), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run(16'h0ABC, 0, 1'b0, 0);

        // HALT ignores fetch_done until reset
        run(16'h8000, 0, 1'b0, 0);
        chk("halted_holds", 32'(halted), 32'd1);
        rst = 1'b1;
        #1;
        chk("reset_from_halt", 32'(act), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run(16'h1123, 0, 1'b0, 0);

        @(posedge clk); #1;
        chk("trace_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
